// File: rtl/imem_responder_pkg.sv
// Shared types for the Y86 instruction-memory responder.
// FSM encoding, fetch-window sizing and a byte-lane helper.
package imem_pkg;

    localparam int INSTR_BYTES = 10;
    localparam int INSTR_W = 8 * INSTR_BYTES;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    // Bit offset of byte lane idx inside a [0:INSTR_W-1] window.
    function automatic logic [6:0] byte_lsb(
        input logic [CNT_W-1:0] idx
    );
        return {idx, 3'b000};
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side request/response bundle for imem_responder.
// master = fetch stage, slave = responder.
interface imem_responder_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = 64
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:INSTR_W-1] rsp_instr;
    logic              rsp_error;

    modport master (
        output req_valid,
        output req_pc,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_instr,
        input  rsp_error
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_instr,
        output rsp_error
    );

endinterface

// File: rtl/imem_byte_ram.sv
// Single-port byte RAM, synchronous write-first read.
// Contents are not reset.
module imem_byte_ram #(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            o_rdata <= i_wdata;
        end else begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Y86 fetch responder: byte-serial 10-byte window read from a byte RAM.
// Define IMEM_WRAP_EN to wrap windows modulo MEM_BYTES (no error path).
module imem_responder
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_responder_if.slave   bus,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(INSTR_BYTES - 1);

    state_e             r_state;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_rsp_error;
    logic [0:INSTR_W-1] r_instr;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_idx;
    logic [AW-1:0]      r_pc;
    logic               r_pend;
    logic               r_all_issued;
    logic               r_oob;

    logic               w_oob;
    logic               w_issue;
    logic [AW-1:0]      w_rd_addr;
    logic [AW-1:0]      w_ram_addr;
    logic [7:0]         w_rdata;
    logic               w_unused;

`ifdef IMEM_WRAP_EN
    assign w_oob = 1'b0;
`else
    logic [ADDR_W:0] w_end;
    assign w_end = {1'b0, bus.req_pc}
                 + (ADDR_W+1)'(INSTR_BYTES);
    assign w_oob = w_end > (ADDR_W+1)'(MEM_BYTES);
`endif

    assign w_unused = ^{wr_addr[ADDR_W-1:AW],
                        bus.req_pc[ADDR_W-1:AW]};

    // Loader owns the port whenever it writes; fetch just waits.
    assign w_issue = (r_state == S_FETCH)
                   && !r_oob
                   && !r_all_issued
                   && !wr_en;

    assign w_rd_addr = r_pc + AW'(r_cnt);
    assign w_ram_addr = wr_en ? wr_addr[AW-1:0]
                              : w_rd_addr;

    imem_byte_ram #(
        .DEPTH (MEM_BYTES),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (wr_en),
        .i_addr  (w_ram_addr),
        .i_wdata (wr_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_error  <= 1'b0;
            r_instr      <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pc         <= '0;
            r_pend       <= 1'b0;
            r_all_issued <= 1'b0;
            r_oob        <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_idx <= r_cnt;
                if (r_cnt == LAST) begin
                    r_all_issued <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_pc         <= bus.req_pc[AW-1:0];
                        r_oob        <= w_oob;
                        r_cnt        <= '0;
                        r_all_issued <= 1'b0;
                        r_instr      <= '0;
                        r_rsp_error  <= 1'b0;
                        r_req_ready  <= 1'b0;
                        r_state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Error windows skip the RAM and answer after a fixed settle cycle.
                    if (r_oob) begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_pend) begin
                        r_instr[byte_lsb(r_idx) +: 8] <= w_rdata;
                        if (r_idx == LAST) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_instr = r_instr;
    assign bus.rsp_error = r_rsp_error;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder against a byte-array model.
// Covers reset, latency, stalls, error/wrap windows and back-to-back.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int MEM = 256;
    typedef logic [0:INSTR_W-1] win_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [63:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;

    imem_responder_if #(.ADDR_W(64)) bus ();

    imem_responder #(
        .MEM_BYTES (MEM),
        .ADDR_W    (64)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_model [MEM];
    int n_pass = 0;
    int n_total = 0;

    function automatic logic ref_oob(input logic [63:0] pc);
`ifdef IMEM_WRAP_EN
        return 1'b0;
`else
        logic [64:0] e;
        e = {1'b0, pc} + 65'd10;
        return e > 65'd256;
`endif
    endfunction

    function automatic win_t ref_window(input logic [63:0] pc);
        win_t w;
        logic [63:0] a;
        w = '0;
        for (int k = 0; k < INSTR_BYTES; k++) begin
            a = pc + 64'(k);
            w[8*k +: 8] = mem_model[a[7:0]];
        end
        return w;
    endfunction

    task automatic write_byte(input logic [63:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        mem_model[a[7:0]] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_fetch(
        input  logic [63:0] pc,
        input  logic [15:0] wmask,
        input  logic [63:0] waddr,
        input  logic [7:0]  wdata,
        output int          lat,
        output win_t        instr,
        output logic        err
    );
        int guard;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_pc = pc;
        bus.rsp_ready = 1'b0;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        lat = -1;
        if (guard < 50) begin
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat = 0;
            while (lat < 60) begin
                if (lat < 16 && wmask[lat]) begin
                    wr_en = 1'b1;
                    wr_addr = waddr;
                    wr_data = wdata;
                    mem_model[waddr[7:0]] = wdata;
                end
                @(posedge clk);
                lat++;
                @(negedge clk);
                wr_en = 1'b0;
                if (bus.rsp_valid === 1'b1) break;
            end
        end
        wr_en = 1'b0;
        bus.req_valid = 1'b0;
        instr = bus.rsp_instr;
        err = bus.rsp_error;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_error} !== 3'b100) begin
            $display("FAIL reset_async: got %b want 100",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_error});
        end else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_error} !== 3'b100) begin
            $display("FAIL reset_flags: got %b want 100",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_error});
        end else n_pass++;
        n_total++;
        if (bus.rsp_instr !== '0) begin
            $display("FAIL reset_instr: got %h want 0", bus.rsp_instr);
        end else n_pass++;
    endtask

    task automatic load_random();
        for (int a = 0; a < MEM; a++) begin
            write_byte(64'(a), 8'($urandom));
        end
    endtask

    task automatic test_basic();
        logic [7:0] prog [10];
        int lat;
        win_t w;
        logic e;
        prog = '{8'h61, 8'h23, 8'h63, 8'h3F, 8'h10,
                 8'h10, 8'h91, 8'h40, 8'h01, 8'h04};
        for (int k = 0; k < 10; k++) write_byte(64'(32 + k), prog[k]);
        do_fetch(64'd32, 16'h0, 64'h0, 8'h0, lat, w, e);
        n_total++;
        if (lat !== 11) $display("FAIL basic_lat: got %0d want 11", lat);
        else n_pass++;
        n_total++;
        if (w !== 80'h6123633F101091400104) begin
            $display("FAIL basic_instr: got %h want 6123633f101091400104", w);
        end else n_pass++;
        n_total++;
        if (e !== 1'b0) $display("FAIL basic_err: got %b want 0", e);
        else n_pass++;
        finish_rsp();
    endtask

    task automatic test_hold();
        int lat;
        win_t w;
        win_t exp;
        logic e;
        exp = ref_window(64'd32);
        do_fetch(64'd32, 16'h0, 64'h0, 8'h0, lat, w, e);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_total++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_instr}
                !== {1'b1, 1'b0, exp}) begin
                $display("FAIL hold_c%0d: got v=%b r=%b %h want v=1 r=0 %h",
                         c, bus.rsp_valid, bus.req_ready, bus.rsp_instr, exp);
            end else n_pass++;
        end
        finish_rsp();
        n_total++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            $display("FAIL hold_release: got %b want 01",
                     {bus.rsp_valid, bus.req_ready});
        end else n_pass++;
    endtask

    task automatic test_error();
        logic [63:0] pcs [4];
        int lat;
        int exp_lat;
        win_t w;
        win_t exp;
        logic e;
        logic exp_e;
        pcs = '{64'd250, 64'd246, 64'd247, 64'hFFFF_FFFF_FFFF_FFFC};
        for (int i = 0; i < 4; i++) begin
            exp_e = ref_oob(pcs[i]);
            exp = exp_e ? win_t'(0) : ref_window(pcs[i]);
            exp_lat = exp_e ? 2 : 11;
            do_fetch(pcs[i], 16'h0, 64'h0, 8'h0, lat, w, e);
            n_total++;
            if (lat !== exp_lat) begin
                $display("FAIL err_lat pc=%h: got %0d want %0d",
                         pcs[i], lat, exp_lat);
            end else n_pass++;
            n_total++;
            if ({e, w} !== {exp_e, exp}) begin
                $display("FAIL err_rsp pc=%h: got %b %h want %b %h",
                         pcs[i], e, w, exp_e, exp);
            end else n_pass++;
            finish_rsp();
        end
    endtask

    task automatic test_stall();
        int lat;
        win_t w;
        win_t exp;
        logic e;
        logic [7:0] nb;
        exp = ref_window(64'd32);
        do_fetch(64'd32, 16'b0101_0100, 64'd100, 8'($urandom),
                 lat, w, e);
        n_total++;
        if (lat !== 14) $display("FAIL stall3_lat: got %0d want 14", lat);
        else n_pass++;
        n_total++;
        if (w !== exp) $display("FAIL stall3_instr: got %h want %h", w, exp);
        else n_pass++;
        finish_rsp();

        nb = ~mem_model[41];
        mem_model[41] = nb;
        exp = ref_window(64'd32);
        do_fetch(64'd32, 16'b1, 64'd41, nb, lat, w, e);
        n_total++;
        if (lat !== 12) $display("FAIL late_lat: got %0d want 12", lat);
        else n_pass++;
        n_total++;
        if (w[72:79] !== nb) begin
            $display("FAIL late_byte9: got %h want %h", w[72:79], nb);
        end else n_pass++;
        n_total++;
        if (w !== exp) $display("FAIL late_instr: got %h want %h", w, exp);
        else n_pass++;
        finish_rsp();

        exp = ref_window(64'd32);
        nb = ~mem_model[32];
        do_fetch(64'd32, 16'b10_0000, 64'd32, nb, lat, w, e);
        n_total++;
        if ({lat == 12, w} !== {1'b1, exp}) begin
            $display("FAIL early_instr: got lat=%0d %h want lat=12 %h",
                     lat, w, exp);
        end else n_pass++;
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        int lat;
        win_t w;
        win_t exp;
        logic e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_pc = 64'd32;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            $display("FAIL midrst_async: got %b want 01",
                     {bus.rsp_valid, bus.req_ready});
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            $display("FAIL midrst_idle: got %b want 01",
                     {bus.rsp_valid, bus.req_ready});
        end else n_pass++;
        exp = ref_window(64'd32);
        do_fetch(64'd32, 16'h0, 64'h0, 8'h0, lat, w, e);
        n_total++;
        if ({lat == 11, w} !== {1'b1, exp}) begin
            $display("FAIL midrst_ram: got lat=%0d %h want lat=11 %h",
                     lat, w, exp);
        end else n_pass++;
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        int t;
        win_t exp1;
        win_t exp2;
        exp1 = ref_window(64'd32);
        exp2 = ref_window(64'd42);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_pc = 64'd32;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_pc = 64'd42;
        t = 0;
        while (bus.rsp_valid !== 1'b1 && t < 60) begin
            @(posedge clk);
            t++;
            @(negedge clk);
        end
        n_total++;
        if ({t == 11, bus.rsp_instr} !== {1'b1, exp1}) begin
            $display("FAIL b2b_first: got lat=%0d %h want lat=11 %h",
                     t, bus.rsp_instr, exp1);
        end else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            $display("FAIL b2b_gap: got %b want 01",
                     {bus.rsp_valid, bus.req_ready});
        end else n_pass++;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        t = 1;
        while (bus.rsp_valid !== 1'b1 && t < 60) begin
            @(posedge clk);
            t++;
            @(negedge clk);
        end
        n_total++;
        if ({t == 12, bus.rsp_instr} !== {1'b1, exp2}) begin
            $display("FAIL b2b_second: got gap=%0d %h want gap=12 %h",
                     t, bus.rsp_instr, exp2);
        end else n_pass++;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] pc;
        logic [15:0] mask;
        logic [63:0] wa;
        logic [7:0]  base;
        int lat;
        int exp_lat;
        win_t w;
        win_t exp;
        logic e;
        logic exp_e;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) pc = {$urandom, $urandom};
            else pc = 64'($urandom_range(0, MEM - 1));
            exp_e = ref_oob(pc);
            mask = exp_e ? 16'h0 : 16'($urandom_range(0, 511));
            base = pc[7:0];
            wa = 64'(8'(base + 8'd10 + 8'($urandom_range(0, 235))));
            exp = exp_e ? win_t'(0) : ref_window(pc);
            exp_lat = exp_e ? 2 : 11 + $countones(mask);
            do_fetch(pc, mask, wa, 8'($urandom), lat, w, e);
            n_total++;
            if ({lat == exp_lat, e, w} !== {1'b1, exp_e, exp}) begin
                $display("FAIL rand%0d pc=%h: got lat=%0d e=%b %h want lat=%0d e=%b %h",
                         i, pc, lat, e, w, exp_lat, exp_e, exp);
            end else n_pass++;
            finish_rsp();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_pc = '0;
        bus.rsp_ready = 1'b0;
        #1;
        test_reset();
        load_random();
        test_basic();
        test_hold();
        test_error();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
